// File: rtl/udp_pkg.sv
// Shared types for the payload forwarder: the FIFO entry layout and the
// terminator entry written when an overflowed packet is cut short.
package udp_pkg;

  typedef struct packed {
    logic       err;
    logic       last;
    logic [7:0] data;
  } fwd_entry_t;

  localparam fwd_entry_t FWD_TERM_ENTRY = '{err: 1'b1, last: 1'b1, data: 8'h00};

endpackage

// File: rtl/payload_forwarder_if.sv
// Byte-stream bundle around payload_forwarder: upstream qualified bytes in,
// valid/ready stream out, plus occupancy and statistics.
interface payload_forwarder_if #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [7:0]       data_in;
  logic             data_valid_in;
  logic             packet_last;
  logic             fwd_enable;
  logic             drop_enable;

  logic [7:0]       m_data;
  logic             m_valid;
  logic             m_last;
  logic             m_error;
  logic             m_ready;

  logic [LW-1:0]    fifo_level;
  logic [CNT_W-1:0] fwd_pkt_count;
  logic [CNT_W-1:0] drop_pkt_count;
  logic [CNT_W-1:0] ovf_pkt_count;

  modport master (
    output data_in, data_valid_in, packet_last, fwd_enable, drop_enable, m_ready,
    input  m_data, m_valid, m_last, m_error,
    input  fifo_level, fwd_pkt_count, drop_pkt_count, ovf_pkt_count
  );

  modport slave (
    input  data_in, data_valid_in, packet_last, fwd_enable, drop_enable, m_ready,
    output m_data, m_valid, m_last, m_error,
    output fifo_level, fwd_pkt_count, drop_pkt_count, ovf_pkt_count
  );

endinterface

// File: rtl/fwd_fifo.sv
// First-word-fall-through FIFO of fwd_entry_t. Occupancy carries the extra
// bit that separates full from empty; pointers wrap naturally.
module fwd_fifo
  import udp_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  fwd_entry_t             wr_entry,
  output logic                   full,
  input  logic                   rd_en,
  output fwd_entry_t             rd_entry,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  fwd_entry_t     r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [LW-1:0]  r_level;
  logic           w_push;
  logic           w_pop;

  assign full   = (r_level == LW'(DEPTH));
  assign empty  = (r_level == '0);
  assign w_push = wr_en && !full;
  assign w_pop  = rd_en && !empty;
  assign level  = r_level;

  // Head is forced to zero when empty so the stale array never leaks out.
  assign rd_entry = empty ? fwd_entry_t'('0) : r_mem[r_rd_ptr];

  // NOTE: storage is deliberately not reset; validity is tracked by r_level,
  // so a reset only needs to clear pointers and occupancy.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_entry;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/payload_forwarder.sv
// Forwards qualified payload bytes into an elastic FIFO, terminating packets
// that overflow with an error entry. Statistics enabled by PAYLOAD_FWD_STATS_EN.
module payload_forwarder
  import udp_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  payload_forwarder_if.slave  bus
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          w_full;
  logic          w_empty;
  logic          w_accept;
  logic          w_term_wr;
  logic          w_ovf;
  logic          w_wr_en;
  logic          w_rd_en;
  fwd_entry_t    w_wr_entry;
  fwd_entry_t    w_rd_entry;
  logic [LW-1:0] w_level;

  logic          r_term_pending;
  logic          r_discard;

  assign w_accept  = bus.data_valid_in && bus.fwd_enable && !r_discard;
  assign w_term_wr = r_term_pending && !w_full;
  // A byte colliding with the terminator write is lost just like a full FIFO.
  assign w_ovf     = w_accept && (w_full || w_term_wr);
  assign w_wr_en   = w_term_wr || (w_accept && !w_full);
  assign w_wr_entry = w_term_wr ? FWD_TERM_ENTRY
                                : fwd_entry_t'({1'b0, bus.packet_last, bus.data_in});
  assign w_rd_en   = !w_empty && bus.m_ready;

  fwd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (w_wr_en),
    .wr_entry (w_wr_entry),
    .full     (w_full),
    .rd_en    (w_rd_en),
    .rd_entry (w_rd_entry),
    .empty    (w_empty),
    .level    (w_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_term_pending <= 1'b0;
      r_discard      <= 1'b0;
    end else begin
      if (w_ovf)          r_term_pending <= 1'b1;
      else if (w_term_wr) r_term_pending <= 1'b0;

      if (w_ovf && !bus.packet_last)
        r_discard <= 1'b1;
      else if (r_discard && bus.data_valid_in && bus.packet_last)
        r_discard <= 1'b0;
    end
  end

  assign bus.m_valid    = !w_empty;
  assign bus.m_data     = w_rd_entry.data;
  assign bus.m_last     = w_rd_entry.last;
  assign bus.m_error    = w_rd_entry.err;
  assign bus.fifo_level = w_level;

`ifdef PAYLOAD_FWD_STATS_EN
  logic [CNT_W-1:0] r_fwd_cnt;
  logic [CNT_W-1:0] r_drop_cnt;
  logic [CNT_W-1:0] r_ovf_cnt;
  logic             w_pop_good;
  logic             w_pop_bad;
  logic             w_drop_pkt;

  assign w_pop_good = w_rd_en && w_rd_entry.last && !w_rd_entry.err;
  assign w_pop_bad  = w_rd_en && w_rd_entry.last &&  w_rd_entry.err;
  assign w_drop_pkt = bus.data_valid_in && bus.drop_enable && bus.packet_last;

  // Counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fwd_cnt  <= '0;
      r_drop_cnt <= '0;
      r_ovf_cnt  <= '0;
    end else begin
      if (w_pop_good && (r_fwd_cnt  != '1)) r_fwd_cnt  <= r_fwd_cnt  + CNT_W'(1);
      if (w_pop_bad  && (r_ovf_cnt  != '1)) r_ovf_cnt  <= r_ovf_cnt  + CNT_W'(1);
      if (w_drop_pkt && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
    end
  end

  assign bus.fwd_pkt_count  = r_fwd_cnt;
  assign bus.drop_pkt_count = r_drop_cnt;
  assign bus.ovf_pkt_count  = r_ovf_cnt;
`else
  assign bus.fwd_pkt_count  = '0;
  assign bus.drop_pkt_count = '0;
  assign bus.ovf_pkt_count  = '0;
`endif

endmodule

// File: tb/tb_payload_forwarder.sv
// Directed bench for payload_forwarder: forwarding, dropping, overflow
// termination, output backpressure and mid-packet reset.
module tb_payload_forwarder;

  localparam int DEPTH = 16;
  localparam int CNT_W = 16;
`ifdef PAYLOAD_FWD_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif
  localparam logic [CNT_W-1:0] E1 = CNT_W'(STATS);

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  logic [9:0] got [$];

  payload_forwarder_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  payload_forwarder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every byte the consumer takes, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && bus.m_valid && bus.m_ready)
      got.push_back({bus.m_error, bus.m_last, bus.m_data});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] d, input logic v, input logic last,
                       input logic fwd, input logic drop);
    bus.data_in       = d;
    bus.data_valid_in = v;
    bus.packet_last   = last;
    bus.fwd_enable    = fwd;
    bus.drop_enable   = drop;
  endtask

  task automatic idle();
    drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    idle();
    bus.m_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    got.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (bus.m_valid !== 1'b0) $display("FAIL reset_m_valid: got %0b want 0", bus.m_valid); else n_pass++;
    n_checks++; if (bus.m_data !== 8'h00) $display("FAIL reset_m_data: got %02h want 00", bus.m_data); else n_pass++;
    n_checks++; if (bus.m_last !== 1'b0) $display("FAIL reset_m_last: got %0b want 0", bus.m_last); else n_pass++;
    n_checks++; if (bus.m_error !== 1'b0) $display("FAIL reset_m_error: got %0b want 0", bus.m_error); else n_pass++;
    n_checks++; if (bus.fifo_level !== 5'd0) $display("FAIL reset_level: got %0d want 0", bus.fifo_level); else n_pass++;
    n_checks++; if (bus.fwd_pkt_count !== '0) $display("FAIL reset_fwd_cnt: got %0d want 0", bus.fwd_pkt_count); else n_pass++;
    n_checks++; if (bus.drop_pkt_count !== '0) $display("FAIL reset_drop_cnt: got %0d want 0", bus.drop_pkt_count); else n_pass++;
    n_checks++; if (bus.ovf_pkt_count !== '0) $display("FAIL reset_ovf_cnt: got %0d want 0", bus.ovf_pkt_count); else n_pass++;
  endtask

  // Streaming at one byte per cycle: each byte is visible right after its write edge.
  task automatic test_forward();
    logic [7:0] exp_d;
    logic [9:0] exp_e;
    do_reset();
    bus.m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_d = 8'(8'h11 + i);
      drive(exp_d, 1'b1, (i == 4), 1'b1, 1'b0);
      tick();
      n_checks++; if (bus.m_valid !== 1'b1) $display("FAIL fwd_valid[%0d]: got %0b want 1", i, bus.m_valid); else n_pass++;
      n_checks++; if (bus.m_data !== exp_d) $display("FAIL fwd_data[%0d]: got %02h want %02h", i, bus.m_data, exp_d); else n_pass++;
      n_checks++; if (bus.m_last !== (i == 4)) $display("FAIL fwd_last[%0d]: got %0b want %0b", i, bus.m_last, (i == 4)); else n_pass++;
      n_checks++; if (bus.m_error !== 1'b0) $display("FAIL fwd_error[%0d]: got %0b want 0", i, bus.m_error); else n_pass++;
      n_checks++; if (bus.fifo_level !== 5'd1) $display("FAIL fwd_level[%0d]: got %0d want 1", i, bus.fifo_level); else n_pass++;
    end
    idle();
    tick();
    n_checks++; if (bus.m_valid !== 1'b0) $display("FAIL fwd_drained: got m_valid %0b want 0", bus.m_valid); else n_pass++;
    n_checks++; if (bus.fifo_level !== 5'd0) $display("FAIL fwd_level_end: got %0d want 0", bus.fifo_level); else n_pass++;
    n_checks++; if (bus.fwd_pkt_count !== E1) $display("FAIL fwd_cnt: got %0d want %0d", bus.fwd_pkt_count, E1); else n_pass++;
    n_checks++; if (bus.ovf_pkt_count !== '0) $display("FAIL fwd_ovf_cnt: got %0d want 0", bus.ovf_pkt_count); else n_pass++;
    n_checks++; if (got.size() !== 5) $display("FAIL fwd_count_out: got %0d bytes want 5", got.size()); else n_pass++;
    for (int k = 0; k < 5 && k < got.size(); k++) begin
      exp_e = {1'b0, (k == 4), 8'(8'h11 + k)};
      n_checks++; if (got[k] !== exp_e) $display("FAIL fwd_stream[%0d]: got %03h want %03h", k, got[k], exp_e); else n_pass++;
    end
  endtask

  task automatic test_drop();
    do_reset();
    bus.m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(8'(8'h11 + i), 1'b1, (i == 4), 1'b0, 1'b1);
      tick();
      n_checks++; if (bus.m_valid !== 1'b0) $display("FAIL drop_valid[%0d]: got %0b want 0", i, bus.m_valid); else n_pass++;
    end
    idle();
    tick();
    n_checks++; if (bus.drop_pkt_count !== E1) $display("FAIL drop_cnt: got %0d want %0d", bus.drop_pkt_count, E1); else n_pass++;
    n_checks++; if (bus.fifo_level !== 5'd0) $display("FAIL drop_level: got %0d want 0", bus.fifo_level); else n_pass++;
    n_checks++; if (got.size() !== 0) $display("FAIL drop_out: got %0d bytes want 0", got.size()); else n_pass++;
  endtask

  // 20-byte packet into a stalled 16-entry FIFO: 16 bytes survive, then a terminator.
  task automatic test_overflow();
    int cyc;
    logic [9:0] exp_e;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(8'(8'h40 + i), 1'b1, (i == 19), 1'b1, 1'b0);
      tick();
    end
    idle();
    tick();
    n_checks++; if (bus.fifo_level !== 5'd16) $display("FAIL ovf_level_full: got %0d want 16", bus.fifo_level); else n_pass++;
    n_checks++; if (bus.m_valid !== 1'b1) $display("FAIL ovf_valid: got %0b want 1", bus.m_valid); else n_pass++;
    n_checks++; if (bus.m_data !== 8'h40) $display("FAIL ovf_head: got %02h want 40", bus.m_data); else n_pass++;
    n_checks++; if (got.size() !== 0) $display("FAIL ovf_stalled_out: got %0d bytes want 0", got.size()); else n_pass++;
    bus.m_ready = 1'b1;
    cyc = 0;
    while (!(got.size() >= 17 && !bus.m_valid) && cyc < 64) begin
      tick();
      cyc++;
    end
    n_checks++; if (cyc >= 64) $display("FAIL ovf_drain_timeout: got %0d cycles want <64", cyc); else n_pass++;
    n_checks++; if (got.size() !== 17) $display("FAIL ovf_count_out: got %0d bytes want 17", got.size()); else n_pass++;
    for (int k = 0; k < 17 && k < got.size(); k++) begin
      exp_e = (k == 16) ? 10'h300 : {2'b00, 8'(8'h40 + k)};
      n_checks++; if (got[k] !== exp_e) $display("FAIL ovf_stream[%0d]: got %03h want %03h", k, got[k], exp_e); else n_pass++;
    end
    n_checks++; if (bus.ovf_pkt_count !== E1) $display("FAIL ovf_cnt: got %0d want %0d", bus.ovf_pkt_count, E1); else n_pass++;
    n_checks++; if (bus.fwd_pkt_count !== '0) $display("FAIL ovf_fwd_cnt: got %0d want 0", bus.fwd_pkt_count); else n_pass++;
    bus.m_ready = 1'b0;
  endtask

  // Head must always be the next unconsumed byte, whatever m_ready does.
  task automatic test_backpressure();
    logic [9:0] exp_e;
    int idx;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      bus.m_ready = (c % 2 == 0);
      if (c < 4) drive(8'(8'h21 + c), 1'b1, (c == 3), 1'b1, 1'b0);
      else       idle();
      tick();
      if (bus.m_valid) begin
        idx = got.size();
        n_checks++; if (bus.m_data !== 8'(8'h21 + idx)) $display("FAIL bp_head[%0d]: got %02h want %02h", c, bus.m_data, 8'(8'h21 + idx)); else n_pass++;
        n_checks++; if (bus.m_last !== (idx == 3)) $display("FAIL bp_last[%0d]: got %0b want %0b", c, bus.m_last, (idx == 3)); else n_pass++;
      end
    end
    n_checks++; if (got.size() !== 4) $display("FAIL bp_count_out: got %0d bytes want 4", got.size()); else n_pass++;
    for (int k = 0; k < 4 && k < got.size(); k++) begin
      exp_e = {1'b0, (k == 3), 8'(8'h21 + k)};
      n_checks++; if (got[k] !== exp_e) $display("FAIL bp_stream[%0d]: got %03h want %03h", k, got[k], exp_e); else n_pass++;
    end
    n_checks++; if (bus.fwd_pkt_count !== E1) $display("FAIL bp_fwd_cnt: got %0d want %0d", bus.fwd_pkt_count, E1); else n_pass++;
    bus.m_ready = 1'b0;
  endtask

  task automatic test_reset_mid_packet();
    int cyc;
    do_reset();
    drive(8'h99, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(8'(8'h51 + i), 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
    end
    idle();
    tick();
    n_checks++; if (bus.fifo_level !== 5'd3) $display("FAIL rstmid_level_before: got %0d want 3", bus.fifo_level); else n_pass++;
    n_checks++; if (bus.drop_pkt_count !== E1) $display("FAIL rstmid_drop_before: got %0d want %0d", bus.drop_pkt_count, E1); else n_pass++;
    rst = 1'b1;
    tick();
    n_checks++; if (bus.m_valid !== 1'b0) $display("FAIL rstmid_valid: got %0b want 0", bus.m_valid); else n_pass++;
    n_checks++; if (bus.fifo_level !== 5'd0) $display("FAIL rstmid_level: got %0d want 0", bus.fifo_level); else n_pass++;
    n_checks++; if (bus.m_data !== 8'h00) $display("FAIL rstmid_data: got %02h want 00", bus.m_data); else n_pass++;
    n_checks++; if (bus.drop_pkt_count !== '0) $display("FAIL rstmid_drop_cnt: got %0d want 0", bus.drop_pkt_count); else n_pass++;
    rst = 1'b0;
    got.delete();
    bus.m_ready = 1'b1;
    drive(8'hA1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    drive(8'hA2, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    idle();
    cyc = 0;
    while (bus.m_valid && cyc < 16) begin
      tick();
      cyc++;
    end
    tick();
    n_checks++; if (got.size() !== 2) $display("FAIL rstmid_count_out: got %0d bytes want 2", got.size()); else n_pass++;
    if (got.size() >= 2) begin
      n_checks++; if (got[0] !== 10'h0A1) $display("FAIL rstmid_byte0: got %03h want 0a1", got[0]); else n_pass++;
      n_checks++; if (got[1] !== 10'h1A2) $display("FAIL rstmid_byte1: got %03h want 1a2", got[1]); else n_pass++;
    end
    n_checks++; if (bus.fwd_pkt_count !== E1) $display("FAIL rstmid_fwd_cnt: got %0d want %0d", bus.fwd_pkt_count, E1); else n_pass++;
    n_checks++; if (bus.ovf_pkt_count !== '0) $display("FAIL rstmid_ovf_cnt: got %0d want 0", bus.ovf_pkt_count); else n_pass++;
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    rst         = 1'b1;
    bus.m_ready = 1'b0;
    idle();
    test_reset();
    test_forward();
    test_drop();
    test_overflow();
    test_backpressure();
    test_reset_mid_packet();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
